// File: rtl/pmu_counter_bank.sv
// rtl/pmu_counter_bank.sv - bank of event counters with handshaked register access
//
// Purpose:
//   N_COUNTERS free-running event counters with a CONFIG register, an
//   overflow status register and an overflow interrupt. Registers are
//   accessed through level-based read/write request lines that come from
//   another clock domain, each closed by a 4-phase IDLE/ACK handshake.
//
// Ports:
//   clk                    sole clock, rising edge
//   rst                    synchronous active-high reset
//   events                 per-cycle event pulses, bit i counts into counter i
//   counter_read_enable    read request level (asynchronous to clk)
//   counter_read_address   read word index, stable while the request is high
//   counter_read_valid     read acknowledge level
//   counter_read_data      captured read data, held until the next capture
//   counter_write_enable   write request level (asynchronous to clk)
//   counter_write_address  write word index, stable while the request is high
//   counter_write_data     write data, stable while the request is high
//   counter_write_valid    write acknowledge level
//   pmu_overflow_irq       registered OR of (overflow status AND irq enable)
//
// Address map:
//   0                 CONFIG  bit0 count enable, bit1 clear-all (self-clearing),
//                             bit2 irq enable
//   1                 OVF_STATUS, write-1-to-clear
//   2..N_COUNTERS+1   counter (addr-2)
//   others            read as 0, writes ignored, still acknowledged

module pmu_counter_bank #(
    parameter int N_COUNTERS = 23,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_COUNTERS-1:0] events,
    input  logic                  counter_read_enable,
    input  logic [7:0]            counter_read_address,
    output logic                  counter_read_valid,
    output logic [CNT_WIDTH-1:0]  counter_read_data,
    input  logic                  counter_write_enable,
    input  logic [7:0]            counter_write_address,
    input  logic [CNT_WIDTH-1:0]  counter_write_data,
    output logic                  counter_write_valid,
    output logic                  pmu_overflow_irq
);

    localparam logic [7:0] ADDR_CONFIG = 8'd0;
    localparam logic [7:0] ADDR_OVF    = 8'd1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } hs_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  rd_sync1_q, rd_sync2_q;
    logic                  wr_sync1_q, wr_sync2_q;

    hs_state_e             rd_state_q, rd_state_d;
    hs_state_e             wr_state_q, wr_state_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [CNT_WIDTH-1:0]  rd_data_q,  rd_data_d;

    logic [CNT_WIDTH-1:0]  cnt_q [N_COUNTERS];
    logic [CNT_WIDTH-1:0]  cnt_d [N_COUNTERS];
    logic [N_COUNTERS-1:0] ovf_q, ovf_d;
    logic                  cfg_en_q,  cfg_en_d;
    logic                  cfg_irq_q, cfg_irq_d;
    logic                  irq_q,     irq_d;

    // ------------------------------------------------------------------
    // Handshake FSMs. The access itself happens on the IDLE->ACK edge,
    // which is the only edge where a "fire" strobe is high.
    // ------------------------------------------------------------------
    logic rd_fire;
    logic wr_fire;

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            ST_IDLE: if (rd_sync2_q)  rd_state_d = ST_ACK;
            ST_ACK:  if (!rd_sync2_q) rd_state_d = ST_IDLE;
            default: rd_state_d = ST_IDLE;
        endcase
        rd_fire    = (rd_state_q == ST_IDLE) && rd_sync2_q;
        rd_valid_d = (rd_state_d == ST_ACK);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            ST_IDLE: if (wr_sync2_q)  wr_state_d = ST_ACK;
            ST_ACK:  if (!wr_sync2_q) wr_state_d = ST_IDLE;
            default: wr_state_d = ST_IDLE;
        endcase
        wr_fire    = (wr_state_q == ST_IDLE) && wr_sync2_q;
        wr_valid_d = (wr_state_d == ST_ACK);
    end

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic                  wr_is_cfg;
    logic                  wr_is_ovf;
    logic                  clear_all;
    logic [N_COUNTERS-1:0] wr_cnt_hit;

    always_comb begin
        wr_is_cfg = wr_fire && (counter_write_address == ADDR_CONFIG);
        wr_is_ovf = wr_fire && (counter_write_address == ADDR_OVF);
        clear_all = wr_is_cfg && counter_write_data[1];
        wr_cnt_hit = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            wr_cnt_hit[i] = wr_fire && (counter_write_address == 8'(i + 2));
        end
    end

    // ------------------------------------------------------------------
    // Read mux. Built from current register values only, so a capture
    // always sees the state before any same-edge update (including a
    // simultaneous write to the same address).
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] rd_value;

    always_comb begin
        rd_value = '0;
        if (counter_read_address == ADDR_CONFIG) begin
            rd_value[0] = cfg_en_q;
            rd_value[2] = cfg_irq_q;
        end else if (counter_read_address == ADDR_OVF) begin
            rd_value[N_COUNTERS-1:0] = ovf_q;
        end else begin
            for (int i = 0; i < N_COUNTERS; i++) begin
                if (counter_read_address == 8'(i + 2)) begin
                    rd_value = cnt_q[i];
                end
            end
        end
        rd_data_d = rd_fire ? rd_value : rd_data_q;
    end

    // ------------------------------------------------------------------
    // Counters and overflow. Priority per counter:
    //   clear-all > direct write > event increment.
    // An overflow is only flagged when the increment actually happens.
    // ------------------------------------------------------------------
    logic [N_COUNTERS-1:0] ovf_set;

    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_all) begin
                cnt_d[i] = '0;
            end else if (wr_cnt_hit[i]) begin
                cnt_d[i] = counter_write_data;
            end else if (cfg_en_q && events[i]) begin
                cnt_d[i]   = cnt_q[i] + CNT_ONE;
                ovf_set[i] = &cnt_q[i];
            end
        end
    end

    // Write-1-to-clear; a flag raised on the same edge survives the clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_all) begin
            ovf_d = '0;
        end else begin
            if (wr_is_ovf) begin
                ovf_d = ovf_d & ~counter_write_data[N_COUNTERS-1:0];
            end
            ovf_d = ovf_d | ovf_set;
        end
    end

    // Clear-all is a strobe and is never stored.
    always_comb begin
        cfg_en_d  = cfg_en_q;
        cfg_irq_d = cfg_irq_q;
        if (wr_is_cfg) begin
            cfg_en_d  = counter_write_data[0];
            cfg_irq_d = counter_write_data[2];
        end
        irq_d = cfg_irq_q && (|ovf_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sync1_q <= 1'b0;
            rd_sync2_q <= 1'b0;
            wr_sync1_q <= 1'b0;
            wr_sync2_q <= 1'b0;
            rd_state_q <= ST_IDLE;
            wr_state_q <= ST_IDLE;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < N_COUNTERS; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q      <= '0;
            cfg_en_q   <= 1'b0;
            cfg_irq_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_sync1_q <= counter_read_enable;
            rd_sync2_q <= rd_sync1_q;
            wr_sync1_q <= counter_write_enable;
            wr_sync2_q <= wr_sync1_q;
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < N_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q      <= ovf_d;
            cfg_en_q   <= cfg_en_d;
            cfg_irq_q  <= cfg_irq_d;
            irq_q      <= irq_d;
        end
    end

    assign counter_read_valid  = rd_valid_q;
    assign counter_read_data   = rd_data_q;
    assign counter_write_valid = wr_valid_q;
    assign pmu_overflow_irq    = irq_q;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// tb/tb_pmu_counter_bank.sv - self-checking bench for pmu_counter_bank

module tb_pmu_counter_bank;

    localparam int N       = 23;
    localparam int TIMEOUT = 20;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  events;
    logic          counter_read_enable;
    logic [7:0]    counter_read_address;
    logic          counter_read_valid;
    logic [63:0]   counter_read_data;
    logic          counter_write_enable;
    logic [7:0]    counter_write_address;
    logic [63:0]   counter_write_data;
    logic          counter_write_valid;
    logic          pmu_overflow_irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q [$];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [16];

    pmu_counter_bank #(.N_COUNTERS(N), .CNT_WIDTH(64)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .events                (events),
        .counter_read_enable   (counter_read_enable),
        .counter_read_address  (counter_read_address),
        .counter_read_valid    (counter_read_valid),
        .counter_read_data     (counter_read_data),
        .counter_write_enable  (counter_write_enable),
        .counter_write_address (counter_write_address),
        .counter_write_data    (counter_write_data),
        .counter_write_valid   (counter_write_valid),
        .pmu_overflow_irq      (pmu_overflow_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns #1 after the edge where the valid reaches lvl; edges counted from the call.
    task automatic wait_rd(input logic lvl, output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (counter_read_valid !== lvl && edges < TIMEOUT);
    endtask

    task automatic wait_wr(input logic lvl, output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (counter_write_valid !== lvl && edges < TIMEOUT);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [63:0] exp, input string name);
        int e;
        exp_q.push_back(exp);
        @(negedge clk);
        counter_read_address = addr;
        counter_read_enable  = 1'b1;
        wait_rd(1'b1, e);
        check({name, "_rise_lat"}, 64'(e), 64'd3);
        check(name, counter_read_data, exp_q.pop_front());
        @(negedge clk);
        counter_read_enable = 1'b0;
        wait_rd(1'b0, e);
        check({name, "_fall_lat"}, 64'(e), 64'd3);
    endtask

    task automatic wr_start(input logic [7:0] addr, input logic [63:0] data, input string name);
        int e;
        @(negedge clk);
        counter_write_address = addr;
        counter_write_data    = data;
        counter_write_enable  = 1'b1;
        wait_wr(1'b1, e);
        check({name, "_rise_lat"}, 64'(e), 64'd3);
    endtask

    task automatic wr_finish(input string name);
        int e;
        @(negedge clk);
        counter_write_enable = 1'b0;
        wait_wr(1'b0, e);
        check({name, "_fall_lat"}, 64'(e), 64'd3);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [63:0] data, input string name);
        wr_start(addr, data, name);
        wr_finish(name);
    endtask

    task automatic pulse_event(input int idx, input int cycles);
        @(negedge clk);
        events[idx] = 1'b1;
        repeat (cycles) @(negedge clk);
        events[idx] = 1'b0;
    endtask

    initial begin
        int e;

        vecs[0]  = '{1'b0, 8'd0,   64'h0, 64'h0};
        vecs[1]  = '{1'b0, 8'd1,   64'h0, 64'h0};
        vecs[2]  = '{1'b0, 8'd2,   64'h0, 64'h0};
        vecs[3]  = '{1'b0, 8'd24,  64'h0, 64'h0};
        vecs[4]  = '{1'b1, 8'd24,  64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[5]  = '{1'b0, 8'd24,  64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[6]  = '{1'b1, 8'd0,   64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
        vecs[7]  = '{1'b0, 8'd0,   64'h0, 64'h0};
        vecs[8]  = '{1'b1, 8'd0,   64'h4, 64'h0};
        vecs[9]  = '{1'b0, 8'd0,   64'h0, 64'h4};
        vecs[10] = '{1'b1, 8'd0,   64'h0, 64'h0};
        vecs[11] = '{1'b0, 8'd25,  64'h0, 64'h0};
        vecs[12] = '{1'b1, 8'd2,   64'hDEAD_BEEF_0000_0001, 64'h0};
        vecs[13] = '{1'b0, 8'd2,   64'h0, 64'hDEAD_BEEF_0000_0001};
        vecs[14] = '{1'b0, 8'd1,   64'h0, 64'h0};
        vecs[15] = '{1'b0, 8'd255, 64'h0, 64'h0};

        rst                   = 1'b1;
        events                = '0;
        counter_read_enable   = 1'b0;
        counter_read_address  = 8'd0;
        counter_write_enable  = 1'b0;
        counter_write_address = 8'd0;
        counter_write_data    = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_valid", 64'(counter_read_valid), 64'd0);
        check("reset_wr_valid", 64'(counter_write_valid), 64'd0);
        check("reset_rd_data", counter_read_data, 64'd0);
        check("reset_irq", 64'(pmu_overflow_irq), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of plain register accesses.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_wr", i));
            else            do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rd", i));
        end
        check("table_irq", 64'(pmu_overflow_irq), 64'd0);

        // Ten counted events on counter 3.
        do_write(8'd0, 64'h1, "cfg_en");
        pulse_event(3, 10);
        do_read(8'd5, 64'd10, "cnt3_ten");

        // Wrap of counter 0 raises overflow and irq; W1C clears it.
        do_write(8'd2, ALL_ONES, "cnt0_max");
        do_write(8'd0, 64'h5, "cfg_en_irq");
        check("irq_before_wrap", 64'(pmu_overflow_irq), 64'd0);
        pulse_event(0, 1);
        @(posedge clk); #1;
        check("irq_after_wrap", 64'(pmu_overflow_irq), 64'd1);
        do_read(8'd2, 64'd0, "cnt0_wrapped");
        do_read(8'd1, 64'h1, "ovf_bit0");
        do_write(8'd1, 64'h1, "ovf_w1c");
        check("irq_after_w1c", 64'(pmu_overflow_irq), 64'd0);
        do_read(8'd1, 64'h0, "ovf_cleared");

        // Write overrides a same-edge increment; counting resumes next edge.
        @(negedge clk);
        events[1] = 1'b1;
        wr_start(8'd3, 64'd100, "cnt1_load");
        @(posedge clk); #1;
        events[1] = 1'b0;
        wr_finish("cnt1_load");
        do_read(8'd3, 64'd101, "cnt1_after_load");

        // Out-of-range accesses are acknowledged and harmless.
        do_read(8'd200, 64'd0, "oor_read");
        do_write(8'd200, 64'h55, "oor_write");
        do_read(8'd0, 64'h5, "oor_cfg_kept");
        do_read(8'd5, 64'd10, "oor_cnt3_kept");
        do_read(8'd24, 64'h0123_4567_89AB_CDEF, "oor_cnt22_kept");

        // Same-edge overflow set beats a W1C of that bit; other bits clear.
        do_write(8'd6, ALL_ONES, "cnt4_max");
        do_write(8'd7, ALL_ONES, "cnt5_max");
        pulse_event(5, 1);
        do_write(8'd7, ALL_ONES, "cnt5_max2");
        @(negedge clk);
        counter_write_address = 8'd1;
        counter_write_data    = 64'h30;
        counter_write_enable  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        events[4] = 1'b1;
        @(posedge clk); #1;
        check("ovf_race_wr_valid", 64'(counter_write_valid), 64'd1);
        @(negedge clk);
        events[4] = 1'b0;
        wr_finish("ovf_race");
        do_read(8'd1, 64'h10, "ovf_set_wins");
        do_read(8'd6, 64'd0, "cnt4_wrapped");
        check("irq_ovf4", 64'(pmu_overflow_irq), 64'd1);

        // Simultaneous read and write of one address: read sees old value.
        do_write(8'd8, 64'h77, "cnt6_init");
        exp_q.push_back(64'h77);
        @(negedge clk);
        counter_read_address  = 8'd8;
        counter_write_address = 8'd8;
        counter_write_data    = 64'h99;
        counter_read_enable   = 1'b1;
        counter_write_enable  = 1'b1;
        wait_rd(1'b1, e);
        check("rw_same_lat", 64'(e), 64'd3);
        check("rw_same_wr_valid", 64'(counter_write_valid), 64'd1);
        check("rw_same_old", counter_read_data, exp_q.pop_front());
        @(negedge clk);
        counter_read_enable  = 1'b0;
        counter_write_enable = 1'b0;
        wait_rd(1'b0, e);
        check("rw_same_wr_drop", 64'(counter_write_valid), 64'd0);
        do_read(8'd8, 64'h99, "rw_same_new");

        // Clear-all wipes counters and status; only bits 0 and 2 are stored.
        do_write(8'd0, 64'h3, "cfg_clear");
        do_read(8'd3, 64'd0, "clr_cnt1");
        do_read(8'd5, 64'd0, "clr_cnt3");
        do_read(8'd8, 64'd0, "clr_cnt6");
        do_read(8'd1, 64'd0, "clr_ovf");
        do_read(8'd0, 64'h1, "clr_cfg");
        check("clr_irq", 64'(pmu_overflow_irq), 64'd0);

        // Reset during an acknowledged read aborts it; held enable re-requests.
        do_write(8'd0, 64'h5, "cfg_pre_rst");
        exp_q.push_back(64'h5);
        @(negedge clk);
        counter_read_address = 8'd0;
        counter_read_enable  = 1'b1;
        wait_rd(1'b1, e);
        check("pre_rst_data", counter_read_data, exp_q.pop_front());
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", 64'(counter_read_valid), 64'd0);
        check("rst_mid_data", counter_read_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(64'h0);
        wait_rd(1'b1, e);
        check("post_rst_lat", 64'(e), 64'd3);
        check("post_rst_data", counter_read_data, exp_q.pop_front());
        @(negedge clk);
        counter_read_enable = 1'b0;
        wait_rd(1'b0, e);
        check("post_rst_fall", 64'(counter_read_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmu_counter_bank.md
PMU_COUNTER_BANK -- requirements
Module: pmu_counter_bank

Interface
REQ-001: Parameter N_COUNTERS, default 23, number of 64-bit event counters.
REQ-002: Parameter CNT_WIDTH, default 64, counter and data width.
REQ-003: clk  input  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-004: rst  input  1  synchronous active-high reset.
REQ-005: events  input  N_COUNTERS  per-cycle event pulses, bit i increments counter i.
REQ-006: counter_read_enable  input  1  read request level from the AXI handler, asynchronous to clk.
REQ-007: counter_read_address  input  8  read word index, stable while counter_read_enable high.
REQ-008: counter_read_valid  output  1  read acknowledge level.
REQ-009: counter_read_data  output  64  read data, valid while counter_read_valid high.
REQ-010: counter_write_enable  input  1  write request level, asynchronous to clk.
REQ-011: counter_write_address  input  8  write word index, stable while counter_write_enable high.
REQ-012: counter_write_data  input  64  write data, stable while counter_write_enable high.
REQ-013: counter_write_valid  output  1  write acknowledge level.
REQ-014: pmu_overflow_irq  output  1  registered OR of (overflow status AND irq enable).

Function
REQ-015: Address map: 0 = CONFIG, 1 = OVF_STATUS, 2..N_COUNTERS+1 = counter (addr-2); other addresses out of range.
REQ-016: CONFIG bit0 = count enable, bit1 = clear-all (self-clearing, reads 0), bit2 = irq enable; other bits read 0.
REQ-017: counter_read_enable and counter_write_enable each pass a 2-flop synchronizer before use.
REQ-018: Read and write each use an independent 4-phase FSM: IDLE -> ACK -> IDLE.
REQ-019: IDLE -> ACK on edge where synchronized enable is 1; same edge registers data/performs write; valid is 1 in ACK.
REQ-020: ACK -> IDLE on edge where synchronized enable is 0; valid drops on that edge.
REQ-021: Valid rises exactly 3 clk edges after the first edge sampling raw enable high; falls 3 edges after raw enable first sampled low.
REQ-022: Read data is the register value before any same-edge update; counter_read_data holds until next capture, reset value 0.
REQ-023: Out-of-range read returns 0; out-of-range write changes nothing; both are still acknowledged.
REQ-024: Counter i increments by 1 on each edge with events[i]=1 and CONFIG bit0=1.
REQ-025: Counter at 2^64-1 plus event wraps to 0 and sets OVF_STATUS bit i.
REQ-026: Write to counter i loads counter_write_data, overriding a same-edge increment.
REQ-027: Write to OVF_STATUS is write-1-to-clear; a same-edge overflow set wins over clear.
REQ-028: Write to CONFIG with bit1=1 zeroes all counters and OVF_STATUS on that edge; bits 0 and 2 are stored.
REQ-029: Simultaneous read and write to the same address: read returns pre-write value.
REQ-030: pmu_overflow_irq registered one edge after OVF_STATUS/CONFIG change.

Reset
REQ-031: On rst=1 at an edge: counters, OVF_STATUS, CONFIG, synchronizers, counter_read_data = 0; FSMs = IDLE; both valids = 0; irq = 0.
REQ-032: Reset mid-handshake aborts it; after release, a still-high enable is treated as a new request.

Verification
REQ-033: Write CONFIG=0x1, pulse events[3] 10 cycles, read addr 5 -> counter_read_data = 10, valid 3 edges after enable.
REQ-034: Write addr 2 = 0xFFFF_FFFF_FFFF_FFFF, CONFIG=0x5, one events[0] pulse -> counter 0 = 0, OVF_STATUS = 0x1, irq = 1; write OVF_STATUS=0x1 -> irq = 0.
REQ-035: Counting enabled, events[1] constant 1, write addr 3 = 100 -> counter 1 = 100 on write edge, 101 next edge.
REQ-036: Read addr 200 -> data 0, valid asserted; write addr 200 = 0x55 -> no register changes, write valid asserted.
REQ-037: Counters nonzero, write CONFIG = 0x3 -> all counters and OVF_STATUS 0, CONFIG reads 0x1.
REQ-038: Assert rst while read valid high -> valid 0 next edge, data 0; enable held high -> new ack 3 edges after rst release.
